// File: rtl/usb_cmd_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_cmd_parser_if
//  Description : Bundles the RX FIFO pop port, the USB reset handshake and the
//                decoded-command valid/ready port of usb_cmd_parser.
//                "master" is the parser side; "slave" is its environment
//                (RX FIFO, USB reset controller and command controller).
//  Revision    : 1.0  initial release
// ============================================================================
interface usb_cmd_parser_if #(
    parameter int ERR_CNT_W = 8
);
    // RX FIFO pop port
    logic                 rx_empty;
    logic                 rx_read;
    logic [7:0]           rx_rdata;
    // USB reset handshake
    logic                 reset_pending;
    logic                 fifo_flush;
    logic                 reset_ack;
    // Decoded command port
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [7:0]           cmd_id;
    logic [31:0]          cmd_arg0;
    logic [31:0]          cmd_arg1;
    // Framing status
    logic                 framing_error;
    logic [ERR_CNT_W-1:0] error_count;

    modport master (
        input  rx_empty, rx_rdata, reset_pending, cmd_ready,
        output rx_read, fifo_flush, reset_ack, cmd_valid,
               cmd_id, cmd_arg0, cmd_arg1, framing_error, error_count
    );

    modport slave (
        output rx_empty, rx_rdata, reset_pending, cmd_ready,
        input  rx_read, fifo_flush, reset_ack, cmd_valid,
               cmd_id, cmd_arg0, cmd_arg1, framing_error, error_count
    );
endinterface
`default_nettype wire

// File: rtl/usb_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : usb_cmd_parser
//  Description : Pops bytes from the FT1248 RX FIFO, deframes 12-byte host
//                packets ('C','M','D', id, arg0 BE, arg1 BE), presents each
//                command on a valid/ready port and runs the controller side of
//                the USB reset handshake (flush + acknowledge).
//  Revision    : 1.0  initial release
// ============================================================================
module usb_cmd_parser #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter int          ERR_CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    usb_cmd_parser_if.master bus
);

    typedef enum logic [2:0] {
        S_TOKEN = 3'd0,
        S_ID    = 3'd1,
        S_ARG0  = 3'd2,
        S_ARG1  = 3'd3,
        S_VALID = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    localparam logic [7:0] c_TOK_C = 8'h43;
    localparam logic [7:0] c_TOK_M = 8'h4D;
    localparam logic [7:0] c_TOK_D = 8'h44;

    // Registered state
    state_t               r_state;
    logic [1:0]           r_index;      // matched token bytes
    logic [1:0]           r_byte_cnt;   // byte position inside arg0/arg1
    logic                 r_pending;    // a pop is in flight, data arrives now
    logic                 r_active;     // low during and just after reset so no pop fires
    logic [15:0]          r_tmo_cnt;
    logic [7:0]           r_cmd_id;
    logic [31:0]          r_arg0;
    logic [31:0]          r_arg1;
    logic                 r_framing_error;
    logic                 r_flush_pulse;
    logic [ERR_CNT_W-1:0] r_error_count;

    // Next-state values
    state_t               w_state_nxt;
    logic [1:0]           w_index_nxt;
    logic [1:0]           w_byte_cnt_nxt;
    logic [15:0]          w_tmo_cnt_nxt;
    logic [7:0]           w_cmd_id_nxt;
    logic [31:0]          w_arg0_nxt;
    logic [31:0]          w_arg1_nxt;
    logic                 w_fe_nxt;
    logic                 w_flush_nxt;

    logic                 w_rx_read;
    logic                 w_timer_active;
    logic                 w_timeout;
    logic [7:0]           w_expected_tok;

    // Pop whenever a byte is wanted, nothing is in flight and no USB reset is pending
    always_comb begin
        w_rx_read = r_active && !bus.rx_empty && !r_pending && !bus.reset_pending &&
                    ((r_state == S_TOKEN) || (r_state == S_ID) ||
                     (r_state == S_ARG0)  || (r_state == S_ARG1));
    end

    // Inter-byte timer only runs once a packet has started; an idle link never times out
    always_comb begin
        w_timer_active = ((r_state == S_TOKEN) && (r_index != 2'd0)) ||
                         (r_state == S_ID) || (r_state == S_ARG0) || (r_state == S_ARG1);
        w_timeout      = w_timer_active && (r_tmo_cnt == (TIMEOUT_CYCLES - 16'd1));
    end

    // Token byte expected at the current match position
    always_comb begin
        w_expected_tok = c_TOK_C;
        case (r_index)
            2'd1:    w_expected_tok = c_TOK_M;
            2'd2:    w_expected_tok = c_TOK_D;
            default: w_expected_tok = c_TOK_C;
        endcase
    end

    // Next-state logic: reset_pending beats timeout, timeout beats byte capture
    always_comb begin
        w_state_nxt    = r_state;
        w_index_nxt    = r_index;
        w_byte_cnt_nxt = r_byte_cnt;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_cmd_id_nxt   = r_cmd_id;
        w_arg0_nxt     = r_arg0;
        w_arg1_nxt     = r_arg1;
        w_fe_nxt       = 1'b0;
        w_flush_nxt    = 1'b0;

        if (bus.reset_pending && (r_state != S_FLUSH)) begin
            // Partial packet, unaccepted command and any in-flight byte are dropped
            w_state_nxt    = S_FLUSH;
            w_index_nxt    = 2'd0;
            w_byte_cnt_nxt = 2'd0;
            w_tmo_cnt_nxt  = 16'd0;
            w_flush_nxt    = 1'b1;
        end else if (w_timeout) begin
            // A byte landing on this cycle is discarded along with the partial packet
            w_state_nxt    = S_TOKEN;
            w_index_nxt    = 2'd0;
            w_byte_cnt_nxt = 2'd0;
            w_tmo_cnt_nxt  = 16'd0;
            w_fe_nxt       = 1'b1;
        end else begin
            w_tmo_cnt_nxt = w_timer_active ? (r_tmo_cnt + 16'd1) : 16'd0;

            if (r_pending) begin
                w_tmo_cnt_nxt = 16'd0;
                case (r_state)
                    S_TOKEN: begin
                        if (bus.rx_rdata == w_expected_tok) begin
                            if (r_index == 2'd2) begin
                                w_state_nxt = S_ID;
                                w_index_nxt = 2'd0;
                            end else begin
                                w_index_nxt = r_index + 2'd1;
                            end
                        end else begin
                            // A stray 'C' is itself a valid packet start
                            w_fe_nxt    = 1'b1;
                            w_index_nxt = (bus.rx_rdata == c_TOK_C) ? 2'd1 : 2'd0;
                        end
                    end
                    S_ID: begin
                        w_cmd_id_nxt   = bus.rx_rdata;
                        w_byte_cnt_nxt = 2'd0;
                        w_state_nxt    = S_ARG0;
                    end
                    S_ARG0: begin
                        w_arg0_nxt     = {r_arg0[23:0], bus.rx_rdata};
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            w_state_nxt = S_ARG1;
                        end
                    end
                    S_ARG1: begin
                        w_arg1_nxt     = {r_arg1[23:0], bus.rx_rdata};
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            w_state_nxt = S_VALID;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            case (r_state)
                S_VALID: begin
                    if (bus.cmd_ready) begin
                        w_state_nxt = S_TOKEN;
                        w_index_nxt = 2'd0;
                    end
                end
                S_FLUSH: begin
                    if (!bus.reset_pending) begin
                        w_state_nxt = S_TOKEN;
                        w_index_nxt = 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register and pulse/counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_TOKEN;
            r_index         <= 2'd0;
            r_byte_cnt      <= 2'd0;
            r_pending       <= 1'b0;
            r_active        <= 1'b0;
            r_tmo_cnt       <= 16'd0;
            r_cmd_id        <= 8'd0;
            r_arg0          <= 32'd0;
            r_arg1          <= 32'd0;
            r_framing_error <= 1'b0;
            r_flush_pulse   <= 1'b0;
            r_error_count   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_index         <= w_index_nxt;
            r_byte_cnt      <= w_byte_cnt_nxt;
            r_pending       <= w_rx_read;
            r_active        <= 1'b1;
            r_tmo_cnt       <= w_tmo_cnt_nxt;
            r_cmd_id        <= w_cmd_id_nxt;
            r_arg0          <= w_arg0_nxt;
            r_arg1          <= w_arg1_nxt;
            r_framing_error <= w_fe_nxt;
            r_flush_pulse   <= w_flush_nxt;
            if (w_fe_nxt && (r_error_count != {ERR_CNT_W{1'b1}})) begin
                r_error_count <= r_error_count + 1'b1;
            end
        end
    end

    assign bus.rx_read       = w_rx_read;
    assign bus.fifo_flush    = r_flush_pulse;
    assign bus.reset_ack     = r_flush_pulse;
    assign bus.cmd_valid     = (r_state == S_VALID);
    assign bus.cmd_id        = r_cmd_id;
    assign bus.cmd_arg0      = r_arg0;
    assign bus.cmd_arg1      = r_arg1;
    assign bus.framing_error = r_framing_error;
    assign bus.error_count   = r_error_count;

endmodule
`default_nettype wire

// File: tb/tb_usb_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_cmd_parser
//  Description : Self-checking bench for usb_cmd_parser. A queue-based RX FIFO
//                feeds the parser; a stream-level deframing model predicts the
//                commands and framing errors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_usb_cmd_parser;

    localparam logic [15:0] TIMEOUT = 16'd100;
    localparam int          ERR_W   = 8;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] a0;
        logic [31:0] a1;
    } cmd_t;

    logic clk = 1'b0;
    logic reset_n;

    usb_cmd_parser_if #(.ERR_CNT_W(ERR_W)) bus ();

    usb_cmd_parser #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .ERR_CNT_W      (ERR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          errors   = 0;
    logic [7:0]  fifo_q[$];
    int          stall_en = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    int          fe_cnt   = 0;
    int          acc_cnt  = 0;
    int          exp_acc  = 0;
    int          m_err    = 0;
    int          m_idx    = 0;
    bit          m_in_body = 0;
    logic [7:0]  m_body[$];
    cmd_t        exp_q[$];
    logic [71:0] last_cmd = '0;
    time         last_pop_t = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat(input int n);
        logic [31:0] v;
        v = n;
        return (n > 255) ? 8'hFF : v[7:0];
    endfunction

    // Stream-level model: scan for "CMD", then take the next nine bytes as a command
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] tok;
        cmd_t       c;
        if (m_in_body) begin
            m_body.push_back(b);
            if (m_body.size() == 9) begin
                c.id = m_body[0];
                c.a0 = {m_body[1], m_body[2], m_body[3], m_body[4]};
                c.a1 = {m_body[5], m_body[6], m_body[7], m_body[8]};
                exp_q.push_back(c);
                exp_acc++;
                m_body.delete();
                m_in_body = 0;
            end
        end else begin
            tok = (m_idx == 0) ? 8'h43 : (m_idx == 1) ? 8'h4D : 8'h44;
            if (b == tok) begin
                m_idx++;
                if (m_idx == 3) begin
                    m_idx     = 0;
                    m_in_body = 1;
                end
            end else begin
                m_err++;
                m_idx = (b == 8'h43) ? 1 : 0;
            end
        end
    endtask

    task automatic model_reset();
        m_idx     = 0;
        m_in_body = 0;
        m_body.delete();
    endtask

    task automatic send(input logic [7:0] b);
        fifo_q.push_back(b);
        model_byte(b);
    endtask

    task automatic send_pkt(input logic [7:0] id, input logic [31:0] a0, input logic [31:0] a1);
        send(8'h43); send(8'h4D); send(8'h44); send(id);
        for (int i = 3; i >= 0; i--) send(a0[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send(a1[i*8 +: 8]);
    endtask

    task automatic wait_cmds(input int target, input int limit);
        int n;
        n = 0;
        while (acc_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (acc_cnt < target) check("cmd_wait_timeout", acc_cnt, target);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (fifo_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (fifo_q.size() != 0) check("drain_timeout", fifo_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // RX FIFO model and cmd_ready driver; data appears the cycle after a pop
    initial begin : fifo_proc
        logic pop;
        logic flush;
        int   stall;
        bus.rx_empty  = 1'b1;
        bus.rx_rdata  = 8'h00;
        bus.cmd_ready = 1'b0;
        stall = 0;
        forever begin
            @(negedge clk);
            pop   = bus.rx_read;
            flush = bus.fifo_flush;
            @(posedge clk);
            #1;
            if (pop) begin
                check("pop_nonempty", fifo_q.size() != 0, 1);
                if (fifo_q.size() != 0) begin
                    bus.rx_rdata = fifo_q.pop_front();
                    last_pop_t   = $time;
                end
            end
            if (flush) fifo_q.delete();
            if (stall > 0) stall--;
            else if (stall_en != 0 && $urandom_range(0, 3) == 0) stall = $urandom_range(1, 6);
            bus.rx_empty = (fifo_q.size() == 0) || (stall > 0);
            case (ready_mode)
                0:       bus.cmd_ready = 1'b1;
                1:       bus.cmd_ready = ($urandom_range(0, 2) != 0);
                default: bus.cmd_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: count framing pulses and score accepted commands
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.framing_error) fe_cnt++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cnt++;
                last_cmd = {bus.cmd_id, bus.cmd_arg0, bus.cmd_arg1};
                check("cmd_expected_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("cmd_fields", last_cmd, exp_q.pop_front());
            end
        end
    end

    initial begin : main
        int   fe0;
        int   acc0;
        int   n;
        int   nf, na, nv, nr;
        time  t1;
        logic [7:0] b;

        reset_n           = 1'b0;
        bus.reset_pending = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {bus.rx_read, bus.fifo_flush, bus.reset_ack, bus.cmd_valid, bus.framing_error}, 5'b0);
        check("rst_err_count", bus.error_count, 0);
        check("rst_cmd", {bus.cmd_id, bus.cmd_arg0, bus.cmd_arg1}, 72'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single well-formed packet
        send_pkt(8'h05, 32'h12345678, 32'h9ABCDEF0);
        wait_cmds(exp_acc, 500);
        wait_drain(500);
        check("p1_accepts", acc_cnt, 1);
        check("p1_cmd", last_cmd, {8'h05, 32'h12345678, 32'h9ABCDEF0});
        check("p1_err_count", bus.error_count, 0);

        // Resync on garbage and on a repeated 'C'
        fe0 = fe_cnt;
        send(8'h00); send(8'h43); send(8'h43); send(8'h4D); send(8'h44); send(8'h01);
        for (int i = 0; i < 8; i++) send(8'h00);
        wait_cmds(exp_acc, 500);
        wait_drain(500);
        check("resync_fe_pulses", fe_cnt - fe0, 2);
        check("resync_cmd", last_cmd, {8'h01, 32'h0, 32'h0});
        check("resync_err_count", bus.error_count, 2);

        // Back-pressure: command must hold steady and no pops while waiting
        ready_mode = 2;
        @(posedge clk);
        #1;
        acc0 = acc_cnt;
        send_pkt(8'hA5, 32'h11223344, 32'h55667788);
        send_pkt(8'h5A, 32'hCAFEF00D, 32'h0BADBEEF);
        n = 0;
        @(negedge clk);
        while (!bus.cmd_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_seen", bus.cmd_valid, 1);
        for (int i = 0; i < 20; i++) begin
            check("hold_valid_noread", {bus.cmd_valid, bus.rx_read}, 2'b10);
            check("hold_data", {bus.cmd_id, bus.cmd_arg0, bus.cmd_arg1},
                  {8'hA5, 32'h11223344, 32'h55667788});
            @(negedge clk);
        end
        check("hold_no_accept", acc_cnt, acc0);
        ready_mode = 0;
        wait_cmds(exp_acc, 500);
        wait_drain(500);
        check("hold_accepts", acc_cnt - acc0, 2);

        // Randomized packets with junk bytes, FIFO stalls and random ready
        stall_en   = 1;
        ready_mode = 1;
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h43) b = 8'h42;
                send(b);
            end
            send_pkt(8'($urandom), 32'($urandom), 32'($urandom));
        end
        wait_cmds(exp_acc, 4000);
        wait_drain(4000);
        stall_en   = 0;
        ready_mode = 0;
        check("rand_accepts", acc_cnt, exp_acc);
        check("rand_fe_pulses", fe_cnt, m_err);
        check("rand_err_count", bus.error_count, sat(m_err));
        check("rand_exp_empty", exp_q.size(), 0);

        // Inter-byte timeout inside a packet
        fe0 = fe_cnt;
        send(8'h43); send(8'h4D); send(8'h44); send(8'h07); send(8'h11);
        n = 0;
        while (fifo_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        @(negedge clk);
        while (!bus.framing_error && n < 300) begin
            @(negedge clk);
            n++;
        end
        t1 = $time;
        check("tmo_seen", bus.framing_error, 1);
        check("tmo_delay_window", ((t1 - last_pop_t) / 10 >= 99) && ((t1 - last_pop_t) / 10 <= 103), 1);
        m_err++;
        model_reset();
        repeat (3) @(negedge clk);
        check("tmo_fe_pulses", fe_cnt - fe0, 1);
        check("tmo_err_count", bus.error_count, sat(m_err));
        send_pkt(8'h33, 32'hDEADBEEF, 32'h01020304);
        wait_cmds(exp_acc, 500);
        wait_drain(500);
        check("tmo_after_cmd", last_cmd, {8'h33, 32'hDEADBEEF, 32'h01020304});

        // USB reset handshake while in the middle of arg1
        fe0  = fe_cnt;
        acc0 = acc_cnt;
        send(8'h43); send(8'h4D); send(8'h44); send(8'h09);
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); send(8'hB1); send(8'hB2);
        wait_drain(500);
        @(posedge clk);
        #1 bus.reset_pending = 1'b1;
        nf = 0; na = 0; nv = 0; nr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nf += int'(bus.fifo_flush);
            na += int'(bus.reset_ack);
            nv += int'(bus.cmd_valid);
            nr += int'(bus.rx_read);
        end
        @(posedge clk);
        #1 bus.reset_pending = 1'b0;
        model_reset();
        check("flush_pulses", nf, 1);
        check("ack_pulses", na, 1);
        check("flush_no_valid_no_read", {nv[7:0], nr[7:0]}, 16'd0);
        repeat (3) @(negedge clk);
        send_pkt(8'h77, 32'h89ABCDEF, 32'h76543210);
        wait_cmds(exp_acc, 500);
        wait_drain(500);
        check("flush_after_cmd", last_cmd, {8'h77, 32'h89ABCDEF, 32'h76543210});
        check("flush_accepts", acc_cnt - acc0, 1);
        check("flush_no_fe", fe_cnt - fe0, 0);

        // Error counter saturation
        for (int i = 0; i < 300; i++) send(8'h00);
        wait_drain(3000);
        check("sat_err_count", bus.error_count, sat(m_err));
        check("sat_is_ff", bus.error_count, 8'hFF);
        check("sat_fe_pulses", fe_cnt, m_err);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 40; i++) send(8'h00);
        repeat (10) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_ctrl", {bus.rx_read, bus.fifo_flush, bus.reset_ack, bus.cmd_valid, bus.framing_error}, 5'b0);
        check("arst_err_count", bus.error_count, 0);
        check("arst_cmd", {bus.cmd_id, bus.cmd_arg0, bus.cmd_arg1}, 72'd0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
